// File: rtl/lcd_char_writer_if.sv
// Request channel into lcd_char_writer: character writes (valid/ready) plus the clear request.
// The master drives the request fields; the slave (lcd_char_writer) returns oREADY.
interface lcd_char_writer_if;
    logic [7:0] iCHAR;
    logic       iROW;
    logic [3:0] iCOL;
    logic       iVALID;
    logic       oREADY;
    logic       iCLEAR;

    modport master (output iCHAR, output iROW, output iCOL, output iVALID, output iCLEAR, input oREADY);
    modport slave  (input iCHAR, input iROW, input iCOL, input iVALID, input iCLEAR, output oREADY);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-up wait, init sequence, then timed (row, col, char) and clear writes.
// Optional macro LCD_CURSOR_SKIP_EN: track the LCD cursor and skip the set-address write when it already matches.
module lcd_char_writer #(
    parameter int PWRUP_WAIT_CYC = 750000,
    parameter int EN_PULSE_CYC   = 16,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLR_WAIT_CYC   = 82000
) (
    input  logic                iCLK,
    input  logic                iRST,
    lcd_char_writer_if.slave    req,
    output logic                oINIT_DONE,
    output logic [7:0]          LCD_DATA,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic                LCD_EN
);

    localparam int MAX_AB  = (PWRUP_WAIT_CYC > CLR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLR_WAIT_CYC;
    localparam int MAX_CD  = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_PWRUP, ST_INIT, ST_IDLE, ST_CLR, ST_SETADDR, ST_WRCHAR
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_EN, PH_WAIT
    } phase_t;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = 8'h38;
            3'd1:    cmd = 8'h38;
            3'd2:    cmd = 8'h0C;
            3'd3:    cmd = 8'h01;
            3'd4:    cmd = 8'h06;
            default: cmd = 8'h00;
        endcase
        return cmd;
    endfunction

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         init_idx_q, init_idx_d;
    logic [7:0]         char_q, char_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               en_q, en_d;
    logic               init_done_q, init_done_d;
`ifdef LCD_CURSOR_SKIP_EN
    logic               row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic               cur_row_q, cur_row_d;
    logic [3:0]         cur_col_q, cur_col_d;
    logic               cur_vld_q, cur_vld_d;
`endif

    logic               in_write;
    logic [CNT_W-1:0]   wait_last;
    logic               w_done;

    // Bus-write status: the clear command needs the long post-strobe wait.
    always_comb begin
        in_write  = (state_q inside {ST_INIT, ST_CLR, ST_SETADDR, ST_WRCHAR});
        wait_last = (!rs_q && (data_q == 8'h01)) ? CLR_LAST : CMD_LAST;
        w_done    = in_write && (phase_q == PH_WAIT) && (cnt_q == wait_last);
    end

    // Next-state logic: bus-write phase sequencer, then the request-level state machine.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        char_d      = char_q;
        data_d      = data_q;
        rs_d        = rs_q;
        init_done_d = init_done_q;
`ifdef LCD_CURSOR_SKIP_EN
        row_d       = row_q;
        col_d       = col_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        cur_vld_d   = cur_vld_q;
`endif

        if (in_write) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_EN;
                    cnt_d   = '0;
                end
                PH_EN: begin
                    if (cnt_q == EN_LAST) begin
                        phase_d = PH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PH_WAIT: begin
                    if (w_done) begin
                        phase_d = PH_SETUP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    phase_d = PH_SETUP;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            phase_d = PH_SETUP;
        end

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d    = ST_INIT;
                    init_idx_d = 3'd0;
                    data_d     = init_cmd(3'd0);
                    rs_d       = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_INIT: begin
                if (w_done) begin
                    if (init_idx_q == 3'd4) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                        data_d     = init_cmd(init_idx_q + 3'd1);
                    end
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                // Clear wins over a simultaneous character request; the character stays pending upstream.
                if (req.iCLEAR) begin
                    state_d = ST_CLR;
                    data_d  = 8'h01;
                    rs_d    = 1'b0;
                    cnt_d   = '0;
`ifdef LCD_CURSOR_SKIP_EN
                    cur_row_d = 1'b0;
                    cur_col_d = 4'd0;
                    cur_vld_d = 1'b1;
`endif
                end else if (req.iVALID) begin
                    char_d = req.iCHAR;
                    cnt_d  = '0;
`ifdef LCD_CURSOR_SKIP_EN
                    row_d  = req.iROW;
                    col_d  = req.iCOL;
                    if (cur_vld_q && (cur_row_q == req.iROW) && (cur_col_q == req.iCOL)) begin
                        state_d = ST_WRCHAR;
                        data_d  = req.iCHAR;
                        rs_d    = 1'b1;
                    end else begin
                        state_d = ST_SETADDR;
                        data_d  = {1'b1, req.iROW, 2'b00, req.iCOL};
                        rs_d    = 1'b0;
                    end
`else
                    state_d = ST_SETADDR;
                    data_d  = {1'b1, req.iROW, 2'b00, req.iCOL};
                    rs_d    = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                if (w_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLR;
                end
            end
            ST_SETADDR: begin
                if (w_done) begin
                    state_d = ST_WRCHAR;
                    data_d  = char_q;
                    rs_d    = 1'b1;
                end else begin
                    state_d = ST_SETADDR;
                end
            end
            ST_WRCHAR: begin
                if (w_done) begin
                    state_d = ST_IDLE;
`ifdef LCD_CURSOR_SKIP_EN
                    // Past column 15 the controller address leaves the visible line, so stop trusting it.
                    cur_row_d = row_q;
                    if (col_q == 4'd15) begin
                        cur_vld_d = 1'b0;
                    end else begin
                        cur_col_d = col_q + 4'd1;
                        cur_vld_d = 1'b1;
                    end
`endif
                end else begin
                    state_d = ST_WRCHAR;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase

        en_d = (phase_d == PH_EN);
    end

    // State and bus registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_PWRUP;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            init_idx_q  <= 3'd0;
            char_q      <= 8'h00;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            init_done_q <= 1'b0;
`ifdef LCD_CURSOR_SKIP_EN
            row_q       <= 1'b0;
            col_q       <= 4'd0;
            cur_row_q   <= 1'b0;
            cur_col_q   <= 4'd0;
            cur_vld_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            char_q      <= char_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            init_done_q <= init_done_d;
`ifdef LCD_CURSOR_SKIP_EN
            row_q       <= row_d;
            col_q       <= col_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            cur_vld_q   <= cur_vld_d;
`endif
        end
    end

    assign req.oREADY = (state_q == ST_IDLE) && !req.iCLEAR;
    assign oINIT_DONE = init_done_q;
    assign LCD_DATA   = data_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboard bench for lcd_char_writer: expected bus writes (RS, DATA, EN-rise cycle) are queued
// as stimulus is driven and compared against the writes captured on each LCD_EN rising edge.
module tb_lcd_char_writer;

    localparam int PW   = 100;
    localparam int ENC  = 4;
    localparam int CMD  = 20;
    localparam int CLR  = 50;
    localparam int WCYC = 1 + ENC + CMD;
    localparam int CCYC = 1 + ENC + CLR;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       oINIT_DONE;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN;

    lcd_char_writer_if bus ();

    lcd_char_writer #(
        .PWRUP_WAIT_CYC (PW),
        .EN_PULSE_CYC   (ENC),
        .CMD_WAIT_CYC   (CMD),
        .CLR_WAIT_CYC   (CLR)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .req        (bus),
        .oINIT_DONE (oINIT_DONE),
        .LCD_DATA   (LCD_DATA),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_EN     (LCD_EN)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [8:0] bus;
        int         cyc;
    } wr_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rst_cyc = 0;
    logic en_prev = 1'b0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];

    logic [3:0] seq_col [5] = '{4'd3, 4'd4, 4'd15, 4'd0, 4'd1};
    logic [7:0] seq_chr [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
`ifdef LCD_CURSOR_SKIP_EN
    bit         seq_skip [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    bit         seq_skip [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    always @(posedge iCLK) cyc <= cyc + 1;

    // Capture each bus write at the LCD_EN rising edge.
    always @(negedge iCLK) begin
        wr_t w;
        if (LCD_EN === 1'b1 && en_prev !== 1'b1) begin
            w.bus = {LCD_RS, LCD_DATA};
            w.cyc = cyc;
            obs_q.push_back(w);
        end
        en_prev <= LCD_EN;
    end

    task automatic get_write(output wr_t w, output bit to);
        int n = 0;
        to = 1'b0;
        while (obs_q.size() == 0 && n < 2000) begin
            @(posedge iCLK);
            n++;
        end
        if (obs_q.size() == 0) begin
            to = 1'b1;
            w  = '0;
        end else begin
            w = obs_q.pop_front();
        end
    endtask

    task automatic wait_ready(output int c, output bit to);
        int n = 0;
        to = 1'b0;
        c  = 0;
        while (1) begin
            @(negedge iCLK);
            #1;
            if (bus.oREADY === 1'b1) begin
                c = cyc;
                break;
            end
            n++;
            if (n >= 2000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_req(input logic row, input logic [3:0] col, input logic [7:0] ch,
                             output int acc, output bit to);
        int n = 0;
        to  = 1'b0;
        acc = 0;
        @(negedge iCLK);
        bus.iROW   = row;
        bus.iCOL   = col;
        bus.iCHAR  = ch;
        bus.iVALID = 1'b1;
        while (1) begin
            #1;
            if (bus.oREADY === 1'b1) begin
                @(negedge iCLK);
                acc = cyc;
                break;
            end
            if (n >= 2000) begin
                to = 1'b1;
                break;
            end
            @(negedge iCLK);
            n++;
        end
        bus.iVALID = 1'b0;
    endtask

    task automatic test_reset;
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        n_cmp++; if (LCD_EN !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b expected 0", LCD_EN); end
        n_cmp++; if (LCD_RS !== 1'b0) begin n_err++; $display("FAIL reset_rs: got %b expected 0", LCD_RS); end
        n_cmp++; if (LCD_DATA !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", LCD_DATA); end
        n_cmp++; if (LCD_RW !== 1'b0) begin n_err++; $display("FAIL reset_rw: got %b expected 0", LCD_RW); end
        n_cmp++; if (bus.oREADY !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", bus.oREADY); end
        n_cmp++; if (oINIT_DONE !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %b expected 0", oINIT_DONE); end
        iRST    = 1'b0;
        rst_cyc = cyc;
    endtask

    task automatic test_init;
        logic [7:0] cmds [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        int  t = rst_cyc + PW + 1;
        int  last_rise = 0;
        int  c;
        int  n;
        bit  to;
        wr_t e, o;
        for (int i = 0; i < 5; i++) begin
            e.bus = {1'b0, cmds[i]};
            e.cyc = t;
            exp_q.push_back(e);
            last_rise = t;
            t = t + ((cmds[i] == 8'h01) ? CCYC : WCYC);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_write(o, to);
            n_cmp++; if (to || o.bus !== e.bus) begin n_err++; $display("FAIL init_bus: got rs/data %h (timeout %0d) expected %h", o.bus, to, e.bus); end
            n_cmp++; if (to || o.cyc !== e.cyc) begin n_err++; $display("FAIL init_time: EN rise at cycle %0d expected %0d", o.cyc, e.cyc); end
        end
        n_cmp++; if (oINIT_DONE !== 1'b0) begin n_err++; $display("FAIL init_done_early: got %b expected 0", oINIT_DONE); end
        n = 0;
        c = -1;
        while (n < 2000) begin
            @(negedge iCLK);
            if (oINIT_DONE === 1'b1) begin
                c = cyc;
                break;
            end
            n++;
        end
        n_cmp++; if (c !== last_rise + ENC + CMD) begin n_err++; $display("FAIL init_done_time: rose at cycle %0d expected %0d", c, last_rise + ENC + CMD); end
        #1;
        n_cmp++; if (bus.oREADY !== 1'b1) begin n_err++; $display("FAIL init_ready: got %b expected 1", bus.oREADY); end
    endtask

    task automatic test_char_write;
        int  acc, c;
        bit  to;
        wr_t e, o;
        drive_req(1'b1, 4'd5, 8'h41, acc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL char_accept: accepted 0 expected 1"); end
        e.bus = {1'b0, 8'hC5}; e.cyc = acc + 1;        exp_q.push_back(e);
        e.bus = {1'b1, 8'h41}; e.cyc = acc + 1 + WCYC; exp_q.push_back(e);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_write(o, to);
            n_cmp++; if (to || o.bus !== e.bus) begin n_err++; $display("FAIL char_bus: got rs/data %h expected %h", o.bus, e.bus); end
            n_cmp++; if (to || o.cyc !== e.cyc) begin n_err++; $display("FAIL char_time: EN rise at cycle %0d expected %0d", o.cyc, e.cyc); end
        end
        wait_ready(c, to);
        n_cmp++; if (to || c !== acc + 2 * WCYC) begin n_err++; $display("FAIL char_latency: ready at cycle %0d expected %0d", c, acc + 2 * WCYC); end
    endtask

    task automatic test_clear_priority;
        int  acc, acc2, c, n;
        bit  to;
        wr_t e, o;
        @(negedge iCLK);
        bus.iCLEAR = 1'b1;
        bus.iVALID = 1'b1;
        bus.iROW   = 1'b0;
        bus.iCOL   = 4'd2;
        bus.iCHAR  = 8'h5A;
        #1;
        n_cmp++; if (bus.oREADY !== 1'b0) begin n_err++; $display("FAIL clr_ready: got %b expected 0", bus.oREADY); end
        @(negedge iCLK);
        acc = cyc;
        bus.iCLEAR = 1'b0;
        e.bus = {1'b0, 8'h01}; e.cyc = acc + 1; exp_q.push_back(e);
        n = 0; acc2 = -1;
        while (n < 2000) begin
            #1;
            if (bus.oREADY === 1'b1) begin
                @(negedge iCLK);
                acc2 = cyc;
                break;
            end
            @(negedge iCLK);
            n++;
        end
        bus.iVALID = 1'b0;
        n_cmp++; if (acc2 !== acc + CCYC + 1) begin n_err++; $display("FAIL clr_held_accept: accepted at cycle %0d expected %0d", acc2, acc + CCYC + 1); end
        e.bus = {1'b0, 8'h82}; e.cyc = acc2 + 1;        exp_q.push_back(e);
        e.bus = {1'b1, 8'h5A}; e.cyc = acc2 + 1 + WCYC; exp_q.push_back(e);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_write(o, to);
            n_cmp++; if (to || o.bus !== e.bus) begin n_err++; $display("FAIL clr_bus: got rs/data %h expected %h", o.bus, e.bus); end
            n_cmp++; if (to || o.cyc !== e.cyc) begin n_err++; $display("FAIL clr_time: EN rise at cycle %0d expected %0d", o.cyc, e.cyc); end
        end
        wait_ready(c, to);
        n_cmp++; if (to || c !== acc2 + 2 * WCYC) begin n_err++; $display("FAIL clr_char_latency: ready at cycle %0d expected %0d", c, acc2 + 2 * WCYC); end
    endtask

    task automatic test_cursor_seq;
        int  acc, c, lat;
        bit  to;
        wr_t e, o;
        @(negedge iCLK);
        bus.iCLEAR = 1'b1;
        @(negedge iCLK);
        acc = cyc;
        bus.iCLEAR = 1'b0;
        e.bus = {1'b0, 8'h01}; e.cyc = acc + 1; exp_q.push_back(e);
        e = exp_q.pop_front();
        get_write(o, to);
        n_cmp++; if (to || o.bus !== e.bus || o.cyc !== e.cyc) begin n_err++; $display("FAIL seq_clear: got %h at %0d expected %h at %0d", o.bus, o.cyc, e.bus, e.cyc); end
        wait_ready(c, to);
        n_cmp++; if (to || c !== acc + CCYC) begin n_err++; $display("FAIL seq_clear_latency: ready at cycle %0d expected %0d", c, acc + CCYC); end
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b0, seq_col[i], seq_chr[i], acc, to);
            n_cmp++; if (to) begin n_err++; $display("FAIL seq_accept%0d: accepted 0 expected 1", i); end
            if (!seq_skip[i]) begin
                e.bus = {1'b0, 1'b1, 1'b0, 2'b00, seq_col[i]}; e.cyc = acc + 1; exp_q.push_back(e);
            end
            e.bus = {1'b1, seq_chr[i]};
            e.cyc = acc + 1 + (seq_skip[i] ? 0 : WCYC);
            exp_q.push_back(e);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                get_write(o, to);
                n_cmp++; if (to || o.bus !== e.bus) begin n_err++; $display("FAIL seq_bus%0d: got rs/data %h expected %h", i, o.bus, e.bus); end
                n_cmp++; if (to || o.cyc !== e.cyc) begin n_err++; $display("FAIL seq_time%0d: EN rise at cycle %0d expected %0d", i, o.cyc, e.cyc); end
            end
            lat = seq_skip[i] ? WCYC : 2 * WCYC;
            wait_ready(c, to);
            n_cmp++; if (to || c !== acc + lat) begin n_err++; $display("FAIL seq_latency%0d: ready at cycle %0d expected %0d", i, c, acc + lat); end
        end
    endtask

    task automatic test_reset_mid;
        int  acc;
        bit  to;
        wr_t e, o;
        drive_req(1'b1, 4'd0, 8'h5A, acc, to);
        n_cmp++; if (to) begin n_err++; $display("FAIL rst_accept: accepted 0 expected 1"); end
        e.bus = {1'b0, 8'hC0}; e.cyc = acc + 1;        exp_q.push_back(e);
        e.bus = {1'b1, 8'h5A}; e.cyc = acc + 1 + WCYC; exp_q.push_back(e);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            get_write(o, to);
            n_cmp++; if (to || o.bus !== e.bus || o.cyc !== e.cyc) begin n_err++; $display("FAIL rst_bus: got %h at %0d expected %h at %0d", o.bus, o.cyc, e.bus, e.cyc); end
        end
        @(negedge iCLK);
        n_cmp++; if ({LCD_EN, LCD_RS} !== 2'b11) begin n_err++; $display("FAIL rst_en_phase: en/rs %b%b expected 11", LCD_EN, LCD_RS); end
        iRST = 1'b1;
        @(negedge iCLK);
        n_cmp++; if (LCD_EN !== 1'b0) begin n_err++; $display("FAIL rst_mid_en: got %b expected 0", LCD_EN); end
        n_cmp++; if (oINIT_DONE !== 1'b0) begin n_err++; $display("FAIL rst_mid_init_done: got %b expected 0", oINIT_DONE); end
        n_cmp++; if (bus.oREADY !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 0", bus.oREADY); end
        iRST    = 1'b0;
        rst_cyc = cyc;
        obs_q.delete();
        exp_q.delete();
        test_init();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iVALID = 1'b0;
        bus.iCLEAR = 1'b0;
        bus.iCHAR  = 8'h00;
        bus.iROW   = 1'b0;
        bus.iCOL   = 4'd0;
        test_reset();
        test_init();
        test_char_write();
        test_clear_priority();
        test_cursor_seq();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
